systolic_temp: RTL and testbench

- Self-contained N×N weight-stationary systolic matrix multiplier: C = A × B, with signed WIDTH-bit elements.
- Reads A and B element-by-element from a shared single-port memory, runs the PE array, then writes C back to the same memory.
- Sits between the NPU controller (which supplies base addresses and a start pulse) and the data memory.

---
 rtl/systolic_temp_pkg.sv | 23 ++
 rtl/systolic_temp_pe.sv | 36 +++
 rtl/systolic_temp.sv | 223 ++++++++++++++++++++++
 tb/tb_systolic_temp.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_temp_pkg.sv
// ============================================================================
// Module   : systolic_types (package)
// Summary  : Shared FSM state encoding and address width for systolic_temp.
// Revision : 1.0
// ============================================================================
`default_nettype none

package systolic_types;

    localparam int c_ADDR_W = 12;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        WAITING_MEMORY_A = 3'd1,
        WAITING_MEMORY_B = 3'd2,
        EXECUTE          = 3'd3,
        WRITEBACK        = 3'd4,
        DONE             = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_temp_pe.sv
// ============================================================================
// Module   : systolic_pe
// Summary  : Weight-stationary PE; forwards activation right, psum down.
// Revision : 1.0
// ============================================================================
`default_nettype none

module systolic_pe #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] act_in,
    input  logic signed [WIDTH-1:0] psum_in,
    input  logic signed [WIDTH-1:0] weight,
    output logic signed [WIDTH-1:0] act_out,
    output logic signed [WIDTH-1:0] psum_out
);

    // Only the low WIDTH bits of the product survive (two's-complement wrap).
    logic signed [WIDTH-1:0] w_prod;
    assign w_prod = act_in * weight;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_out  <= '0;
            psum_out <= '0;
        end else begin
            act_out  <= act_in;
            psum_out <= psum_in + w_prod;
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_temp.sv
// ============================================================================
// Module   : systolic_temp
// Summary  : NxN weight-stationary systolic C = A x B with shared memory I/O.
// Revision : 1.0
// ============================================================================
`default_nettype none

module systolic_temp
    import systolic_types::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    new_data,
    input  logic signed [WIDTH-1:0] mem_read,
    input  logic [c_ADDR_W-1:0]     addr_A,
    input  logic [c_ADDR_W-1:0]     addr_B,
    input  logic [c_ADDR_W-1:0]     addr_C,
    input  logic [3:0]              n,
    output logic                    mem_write,
    output logic signed [WIDTH-1:0] mem_data_write,
    output logic [c_ADDR_W-1:0]     act_addr,
    output logic signed [WIDTH-1:0] weight_output [N][N],
    output logic signed [WIDTH-1:0] data_up [N],
    output logic signed [WIDTH-1:0] result_col [N],
    output state_t                  fsm_state
);

    localparam int IW = $clog2(N);
    localparam int TW = $clog2(3 * N);

    state_t                  r_state;
    state_t                  w_next;
    logic [c_ADDR_W-1:0]     r_base_a;
    logic [c_ADDR_W-1:0]     r_base_b;
    logic [c_ADDR_W-1:0]     r_base_c;
    logic [IW-1:0]           r_last_idx;
    logic [IW-1:0]           r_row;
    logic [IW-1:0]           r_col;
    logic [c_ADDR_W-1:0]     r_elem;
    logic                    r_phase;
    logic [TW-1:0]           r_t;
    logic signed [WIDTH-1:0] r_a [N][N];
    logic signed [WIDTH-1:0] r_w [N][N];
    logic signed [WIDTH-1:0] r_c [N][N];

    logic [3:0]              w_n_m1;
    logic                    w_last_elem;
    logic                    w_exec_last;
    logic [IW-1:0]           w_row_nxt;
    logic [IW-1:0]           w_col_nxt;
    logic [c_ADDR_W-1:0]     w_elem_nxt;

    logic signed [WIDTH-1:0] w_act  [N][N+1];
    logic signed [WIDTH-1:0] w_psum [N+1][N];

    // Out-of-range dimensions fall back to the full array size.
    assign w_n_m1      = (n == 4'd0 || n > 4'(N)) ? 4'(N - 1) : n - 4'd1;
    assign w_last_elem = (r_row == r_last_idx) && (r_col == r_last_idx);
    assign w_exec_last = (r_t == TW'(3 * N - 2));

    always_comb begin
        w_row_nxt  = '0;
        w_col_nxt  = '0;
        w_elem_nxt = '0;
        if (!w_last_elem) begin
            w_elem_nxt = r_elem + c_ADDR_W'(1);
            if (r_col == r_last_idx) begin
                w_row_nxt = r_row + IW'(1);
            end else begin
                w_row_nxt = r_row;
                w_col_nxt = r_col + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:             if (new_data) w_next = WAITING_MEMORY_A;
            WAITING_MEMORY_A: if (r_phase && w_last_elem) w_next = WAITING_MEMORY_B;
            WAITING_MEMORY_B: if (r_phase && w_last_elem) w_next = EXECUTE;
            EXECUTE:          if (w_exec_last) w_next = WRITEBACK;
            WRITEBACK:        if (w_last_elem) w_next = DONE;
            DONE:             w_next = IDLE;
            default:          w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_write      = 1'b0;
        mem_data_write = '0;
        act_addr       = '0;
        unique case (r_state)
            WAITING_MEMORY_A: act_addr = r_base_a + r_elem;
            WAITING_MEMORY_B: act_addr = r_base_b + r_elem;
            WRITEBACK: begin
                mem_write      = 1'b1;
                act_addr       = r_base_c + r_elem;
                mem_data_write = r_c[r_row][r_col];
            end
            default: ;
        endcase
        // Row r of A enters row k skewed by k cycles.
        for (int k = 0; k < N; k++) begin
            data_up[k] = '0;
            if (r_state == EXECUTE) begin
                for (int r = 0; r < N; r++) begin
                    if (r_t == TW'(r + k)) data_up[k] = r_a[r][k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_base_c   <= '0;
            r_last_idx <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_elem     <= '0;
            r_phase    <= 1'b0;
            r_t        <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= '0;
                    r_w[i][j] <= '0;
                    r_c[i][j] <= '0;
                end
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (new_data) begin
                        r_base_a   <= addr_A;
                        r_base_b   <= addr_B;
                        r_base_c   <= addr_C;
                        r_last_idx <= IW'(w_n_m1);
                        r_row      <= '0;
                        r_col      <= '0;
                        r_elem     <= '0;
                        r_phase    <= 1'b0;
                        r_t        <= '0;
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                r_a[i][j] <= '0;
                                r_w[i][j] <= '0;
                            end
                        end
                    end
                end
                WAITING_MEMORY_A, WAITING_MEMORY_B: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        if (r_state == WAITING_MEMORY_A) begin
                            r_a[r_row][r_col] <= mem_read;
                        end else begin
                            r_w[r_row][r_col] <= mem_read;
                        end
                        r_row  <= w_row_nxt;
                        r_col  <= w_col_nxt;
                        r_elem <= w_elem_nxt;
                    end
                end
                EXECUTE: begin
                    r_t <= w_exec_last ? '0 : r_t + TW'(1);
                    // C[r][c] leaves the bottom of column c at t = r + c + N.
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            if (r_t == TW'(r + c + N)) r_c[r][c] <= result_col[c];
                        end
                    end
                end
                WRITEBACK: begin
                    r_row  <= w_row_nxt;
                    r_col  <= w_col_nxt;
                    r_elem <= w_elem_nxt;
                end
                default: ;
            endcase
        end
    end

    assign weight_output = r_w;
    assign fsm_state     = r_state;

    for (genvar c = 0; c < N; c++) begin : g_col_io
        assign w_psum[0][c]  = '0;
        assign result_col[c] = w_psum[N][c];
    end

    for (genvar k = 0; k < N; k++) begin : g_row
        assign w_act[k][0] = data_up[k];
        for (genvar c = 0; c < N; c++) begin : g_col
            systolic_pe #(
                .WIDTH (WIDTH)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .act_in   (w_act[k][c]),
                .psum_in  (w_psum[k][c]),
                .weight   (r_w[k][c]),
                .act_out  (w_act[k][c+1]),
                .psum_out (w_psum[k+1][c])
            );
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_temp.sv
// ============================================================================
// Module   : tb_systolic_temp
// Summary  : Self-checking bench for systolic_temp with a memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_temp;
    import systolic_types::*;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                new_data = 1'b0;
    logic signed [W-1:0] mem_read = '0;
    logic [11:0]         addr_A = '0;
    logic [11:0]         addr_B = '0;
    logic [11:0]         addr_C = '0;
    logic [3:0]          n = '0;
    logic                mem_write;
    logic signed [W-1:0] mem_data_write;
    logic [11:0]         act_addr;
    logic signed [W-1:0] weight_output [N][N];
    logic signed [W-1:0] data_up [N];
    logic signed [W-1:0] result_col [N];
    state_t              fsm_state;

    logic signed [W-1:0] mem    [4096];
    logic signed [W-1:0] wr_mem [4096];
    logic [11:0]         exp_rd [$];
    logic [11:0]         exp_wa [$];
    logic signed [W-1:0] exp_wd [$];
    int                  total = 0;
    int                  bad   = 0;
    bit                  mon_en = 1'b0;

    systolic_temp #(.N(N), .WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .new_data       (new_data),
        .mem_read       (mem_read),
        .addr_A         (addr_A),
        .addr_B         (addr_B),
        .addr_C         (addr_C),
        .n              (n),
        .mem_write      (mem_write),
        .mem_data_write (mem_data_write),
        .act_addr       (act_addr),
        .weight_output  (weight_output),
        .data_up        (data_up),
        .result_col     (result_col),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    // Read data is valid the cycle after the address is presented.
    always @(posedge clk) mem_read <= mem[act_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int neff(input int nv);
        return (nv == 0 || nv > N) ? N : nv;
    endfunction

    task automatic push_reads(input int ba, input int bb, input int nv);
        int ne = neff(nv);
        for (int e = 0; e < ne * ne; e++) begin
            exp_rd.push_back(12'(ba + e));
            exp_rd.push_back(12'(ba + e));
        end
        for (int e = 0; e < ne * ne; e++) begin
            exp_rd.push_back(12'(bb + e));
            exp_rd.push_back(12'(bb + e));
        end
    endtask

    task automatic push_writes(input int ba, input int bb, input int bc, input int nv);
        int ne = neff(nv);
        logic signed [W-1:0] acc;
        for (int r = 0; r < ne; r++) begin
            for (int c = 0; c < ne; c++) begin
                acc = '0;
                for (int k = 0; k < ne; k++) begin
                    acc = acc + mem[ba + r * ne + k] * mem[bb + k * ne + c];
                end
                exp_wa.push_back(12'(bc + r * ne + c));
                exp_wd.push_back(acc);
            end
        end
    endtask

    // Scoreboard monitor: read addresses, write stream, and idle outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fsm_state == WAITING_MEMORY_A || fsm_state == WAITING_MEMORY_B) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 32'(act_addr), 32'hFFFF);
                else chk("rd_addr", {mem_write, act_addr}, {1'b0, exp_rd.pop_front()});
            end else if (fsm_state == WRITEBACK) begin
                chk("wb_strobe", 32'(mem_write), 32'd1);
                if (exp_wa.size() == 0) begin
                    chk("wr_unexpected", 32'(act_addr), 32'hFFFF);
                end else begin
                    chk("wr_addr", 32'(act_addr), 32'(exp_wa.pop_front()));
                    chk("wr_data", 32'(mem_data_write), 32'(exp_wd.pop_front()));
                end
                wr_mem[act_addr] = mem_data_write;
            end else begin
                chk("quiet_outs", {mem_write, act_addr, mem_data_write}, 32'd0);
            end
        end
    end

    task automatic run_op(input int ba, input int bb, input int bc, input int nv);
        int cyc;
        int ne = neff(nv);
        addr_A = 12'(ba);
        addr_B = 12'(bb);
        addr_C = 12'(bc);
        n      = 4'(nv);
        push_reads(ba, bb, nv);
        push_writes(ba, bb, bc, nv);
        @(negedge clk);
        new_data = 1'b1;
        @(posedge clk);
        #1 new_data = 1'b0;
        cyc = 1;
        while (fsm_state !== DONE && cyc < 1000) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("latency", cyc, 32'(4 * ne * ne + 3 * N - 1 + ne * ne + 1));
        @(posedge clk);
        #1 chk("back_idle", 32'(fsm_state), 32'(IDLE));
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wa.size(), 0);
    endtask

    initial begin
        int nz;
        int cyc;

        // Reset state.
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
        chk("rst_memwrite", 32'(mem_write), 32'd0);
        chk("rst_actaddr", 32'(act_addr), 32'd0);
        nz = 0;
        for (int i = 0; i < N; i++) begin
            if (result_col[i] != 0) nz++;
            for (int j = 0; j < N; j++) if (weight_output[i][j] != 0) nz++;
        end
        chk("rst_arrays", nz, 0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Full 4x4 ascending data.
        for (int i = 0; i < 16; i++) begin
            mem[16 + i] = 16'(i + 1);
            mem[32 + i] = 16'(2 * (i + 1));
        end
        run_op(16, 32, 48, 4);
        chk("w00", 32'(weight_output[0][0]), 32'd2);
        chk("w33", 32'(weight_output[3][3]), 32'd32);
        chk("c00", 32'(wr_mem[48]), 32'd180);
        chk("c01", 32'(wr_mem[49]), 32'd200);
        chk("c02", 32'(wr_mem[50]), 32'd220);
        chk("c03", 32'(wr_mem[51]), 32'd240);
        chk("c10", 32'(wr_mem[52]), 32'd404);
        chk("c33", 32'(wr_mem[63]), 32'd1200);

        // Reduced dimension n=2.
        run_op(16, 32, 48, 2);
        chk("n2_c00", 32'(wr_mem[48]), 32'd14);
        chk("n2_c11", 32'(wr_mem[51]), 32'd44);
        chk("n2_w11", 32'(weight_output[1][1]), 32'd8);
        chk("n2_w33", 32'(weight_output[3][3]), 32'd0);

        // Signed: A=-1, B=1.
        for (int i = 0; i < 16; i++) begin
            mem[16 + i] = -16'sd1;
            mem[32 + i] = 16'sd1;
        end
        run_op(16, 32, 48, 4);
        chk("neg_c00", 32'(wr_mem[48]), -32'sd4);
        chk("neg_c33", 32'(wr_mem[63]), -32'sd4);

        // Wrap: A=B=0x7FFF, each product wraps to 1.
        for (int i = 0; i < 16; i++) begin
            mem[16 + i] = 16'h7FFF;
            mem[32 + i] = 16'h7FFF;
        end
        run_op(16, 32, 48, 4);
        chk("wrap_c12", 32'(wr_mem[54]), 32'd4);

        // n=0 acts as full size.
        for (int i = 0; i < 16; i++) begin
            mem[16 + i] = 16'(i + 1);
            mem[32 + i] = 16'(2 * (i + 1));
        end
        run_op(16, 32, 48, 0);
        chk("n0_c33", 32'(wr_mem[63]), 32'd1200);

        // new_data held high, then reset during the second EXECUTE.
        addr_A = 12'd16;
        addr_B = 12'd32;
        addr_C = 12'd48;
        n      = 4'd4;
        push_reads(16, 32, 4);
        push_writes(16, 32, 48, 4);
        @(negedge clk);
        new_data = 1'b1;
        cyc = 0;
        while (fsm_state !== DONE && cyc < 1000) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("held_done", 32'(fsm_state), 32'(DONE));
        @(posedge clk);
        #1 chk("held_idle", 32'(fsm_state), 32'(IDLE));
        push_reads(16, 32, 4);
        @(posedge clk);
        #1 chk("held_restart", 32'(fsm_state), 32'(WAITING_MEMORY_A));
        cyc = 0;
        while (fsm_state !== EXECUTE && cyc < 1000) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("reach_exec", 32'(fsm_state), 32'(EXECUTE));
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_state", 32'(fsm_state), 32'(IDLE));
        chk("abort_memwrite", 32'(mem_write), 32'd0);
        nz = 0;
        for (int i = 0; i < N; i++) begin
            if (result_col[i] != 0) nz++;
            for (int j = 0; j < N; j++) if (weight_output[i][j] != 0) nz++;
        end
        chk("abort_arrays", nz, 0);
        new_data = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("abort_stays_idle", 32'(fsm_state), 32'(IDLE));
        chk("abort_rd_left", exp_rd.size(), 0);
        chk("abort_no_writes", exp_wa.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
